// File: rtl/frame_supervisor.sv
// Frame supervisor: arms on consecutive good SPI frames, gates joint enables in RUN, and
// faults on frame timeout or repeated bad frames. Optional: FRAME_SUPERVISOR_FAULT_LATCH_EN.
module frame_supervisor #(
  parameter int unsigned CLK_FREQ   = 48000000,
  parameter int unsigned TIMEOUT_US = 10000,
  parameter logic [31:0] RX_HEADER  = 32'h74697277,
  parameter int unsigned BAD_LIMIT  = 3,
  parameter int unsigned ARM_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [31:0] header_rx,
  input  logic [7:0]  cmd_enable,
  input  logic        estop_in,
  input  logic        fault_clear,
  output logic [7:0]  joint_enable,
  output logic        frame_accept,
  output logic [1:0]  state,
  output logic        error,
  output logic [31:0] header_tx,
  output logic [15:0] bad_total
);

  localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned ArmW = $clog2(ARM_FRAMES + 1);
  localparam int unsigned BadW = $clog2(BAD_LIMIT + 1);
  localparam logic [31:0] HdrData  = 32'h64617461;
  localparam logic [31:0] HdrEstop = 32'h65737470;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFault = 2'b10,
    StEstop = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ArmW-1:0]   arm_q, arm_d;
  logic [BadW-1:0]   bad_q, bad_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        joint_q, joint_d;
  logic              accept_q;
  logic              error_q, error_d;
  logic [31:0]       header_tx_q, header_tx_d;
  logic [15:0]       bad_total_q, bad_total_d;
  logic              good, bad, run_fault;

  assign good = frame_valid && (header_rx == RX_HEADER);
  assign bad  = frame_valid && (header_rx != RX_HEADER);

`ifndef FRAME_SUPERVISOR_FAULT_LATCH_EN
  logic unused_fault_clear;
  assign unused_fault_clear = fault_clear;
`endif

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    bad_d     = bad_q;
    tmo_d     = tmo_q;
    joint_d   = joint_q;
    run_fault = 1'b0;

    unique case (state_q)
      StIdle: begin
        joint_d = '0;
        if (good) begin
          if (arm_q >= ArmW'(ARM_FRAMES - 1)) begin
            state_d = StRun;
            arm_d   = '0;
            bad_d   = '0;
            tmo_d   = '0;
            joint_d = cmd_enable;
          end else begin
            arm_d = arm_q + ArmW'(1);
          end
        end else if (bad) begin
          arm_d = '0;
        end
      end
      StRun: begin
        if (good) begin
          tmo_d   = '0;
          bad_d   = '0;
          joint_d = cmd_enable;
        end else begin
          if (bad) begin
            if (bad_q == BadW'(BAD_LIMIT - 1)) run_fault = 1'b1;
            else bad_d = bad_q + BadW'(1);
          end
          if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) run_fault = 1'b1;
          else tmo_d = tmo_q + TmoW'(1);
        end
        if (run_fault) begin
          state_d = StFault;
          joint_d = '0;
          bad_d   = '0;
          tmo_d   = '0;
        end
      end
      StFault: begin
        joint_d = '0;
`ifdef FRAME_SUPERVISOR_FAULT_LATCH_EN
        if (fault_clear) begin
          state_d = StIdle;
          arm_d   = '0;
        end
`else
        // The recovering frame counts as the first arming frame.
        if (good) begin
          state_d = StIdle;
          arm_d   = ArmW'(1);
        end
`endif
      end
      StEstop: begin
        joint_d = '0;
        state_d = StIdle;
        arm_d   = '0;
      end
    endcase

    if (estop_in) begin
      state_d = StEstop;
      joint_d = '0;
      arm_d   = '0;
      bad_d   = '0;
      tmo_d   = '0;
    end
  end

  always_comb begin
    error_d     = (state_d == StFault) || (state_d == StEstop);
    header_tx_d = (state_d == StEstop) ? HdrEstop : HdrData;
    bad_total_d = bad_total_q;
    if (bad && (bad_total_q != 16'hFFFF)) bad_total_d = bad_total_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      arm_q       <= '0;
      bad_q       <= '0;
      tmo_q       <= '0;
      joint_q     <= '0;
      accept_q    <= 1'b0;
      error_q     <= 1'b0;
      header_tx_q <= HdrData;
      bad_total_q <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      bad_q       <= bad_d;
      tmo_q       <= tmo_d;
      joint_q     <= joint_d;
      accept_q    <= good;
      error_q     <= error_d;
      header_tx_q <= header_tx_d;
      bad_total_q <= bad_total_d;
    end
  end

  assign state        = state_q;
  assign joint_enable = joint_q;
  assign frame_accept = accept_q;
  assign error        = error_q;
  assign header_tx    = header_tx_q;
  assign bad_total    = bad_total_q;

endmodule

// File: tb/tb_frame_supervisor.sv
// Scoreboard bench for frame_supervisor: a mode-level reference model predicts every
// cycle's outputs; a monitor compares them against the DUT on the falling edge.
module tb_frame_supervisor;

  localparam int          CLK_FREQ       = 1000000;
  localparam int          TIMEOUT_US     = 100;
  localparam int          TIMEOUT_CYCLES = (CLK_FREQ / 1000000) * TIMEOUT_US;
  localparam int          BAD_LIMIT      = 3;
  localparam int          ARM_FRAMES     = 2;
  localparam logic [31:0] RX_HEADER      = 32'h74697277;
  localparam logic [31:0] HDR_DATA       = 32'h64617461;
  localparam logic [31:0] HDR_ESTOP      = 32'h65737470;
  localparam int          M_IDLE = 0, M_RUN = 1, M_FAULT = 2, M_ESTOP = 3;

  logic        clk, rst_n, frame_valid, estop_in, fault_clear;
  logic [31:0] header_rx, header_tx;
  logic [7:0]  cmd_enable, joint_enable;
  logic        frame_accept, error;
  logic [1:0]  state;
  logic [15:0] bad_total;

  frame_supervisor #(
    .CLK_FREQ  (CLK_FREQ),
    .TIMEOUT_US(TIMEOUT_US),
    .RX_HEADER (RX_HEADER),
    .BAD_LIMIT (BAD_LIMIT),
    .ARM_FRAMES(ARM_FRAMES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .header_rx   (header_rx),
    .cmd_enable  (cmd_enable),
    .estop_in    (estop_in),
    .fault_clear (fault_clear),
    .joint_enable(joint_enable),
    .frame_accept(frame_accept),
    .state       (state),
    .error       (error),
    .header_tx   (header_tx),
    .bad_total   (bad_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  st;
    logic [7:0]  je;
    logic        acc;
    logic        err;
    logic [31:0] htx;
    logic [15:0] tot;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, in terms of operating modes and frame history.
  int         m_mode, m_arm, m_bad, m_silent, m_total;
  logic [7:0] m_joint;

  task automatic model_reset();
    m_mode = M_IDLE; m_arm = 0; m_bad = 0; m_silent = 0; m_total = 0; m_joint = 8'h00;
  endtask

  task automatic model_step(input logic fv, input logic [31:0] hdr, input logic [7:0] en,
                            input logic es, input logic clr);
    bit   good, bad;
    exp_t e;
    good = fv && (hdr == RX_HEADER);
    bad  = fv && !good;
    if (bad && m_total < 65535) m_total++;
    if (es) begin
      m_mode = M_ESTOP;
      m_arm  = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (good) begin
            m_arm++;
            if (m_arm >= ARM_FRAMES) begin
              m_mode = M_RUN; m_arm = 0; m_joint = en; m_silent = 0; m_bad = 0;
            end
          end else if (bad) begin
            m_arm = 0;
          end
        end
        M_RUN: begin
          if (good) begin
            m_silent = 0; m_bad = 0; m_joint = en;
          end else begin
            m_silent++;
            if (bad) m_bad++;
            if (m_silent >= TIMEOUT_CYCLES || m_bad >= BAD_LIMIT) m_mode = M_FAULT;
          end
        end
        M_FAULT: begin
`ifdef FRAME_SUPERVISOR_FAULT_LATCH_EN
          if (clr) begin m_mode = M_IDLE; m_arm = 0; end
`else
          if (good) begin m_mode = M_IDLE; m_arm = 1; end
`endif
        end
        default: begin
          m_mode = M_IDLE; m_arm = 0;
        end
      endcase
    end
    e.cyc = cyc + 1;
    e.st  = 2'(m_mode);
    e.je  = (m_mode == M_RUN) ? m_joint : 8'h00;
    e.acc = good;
    e.err = (m_mode == M_FAULT) || (m_mode == M_ESTOP);
    e.htx = (m_mode == M_ESTOP) ? HDR_ESTOP : HDR_DATA;
    e.tot = 16'(m_total);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (state !== mon_e.st || joint_enable !== mon_e.je || frame_accept !== mon_e.acc ||
          error !== mon_e.err || header_tx !== mon_e.htx || bad_total !== mon_e.tot) begin
        n_fail++;
        $display("FAIL scoreboard cyc %0d: got st=%b je=%h acc=%b err=%b htx=%h tot=%0d, expected st=%b je=%h acc=%b err=%b htx=%h tot=%0d",
                 cyc, state, joint_enable, frame_accept, error, header_tx, bad_total,
                 mon_e.st, mon_e.je, mon_e.acc, mon_e.err, mon_e.htx, mon_e.tot);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic fv, input logic [31:0] hdr, input logic [7:0] en,
                      input logic es, input logic clr);
    @(negedge clk);
    frame_valid = fv; header_rx = hdr; cmd_enable = en; estop_in = es; fault_clear = clr;
    model_step(fv, hdr, en, es, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic good(input logic [7:0] en);
    step(1'b1, RX_HEADER, en, 1'b0, 1'b0);
  endtask

  task automatic bad();
    step(1'b1, 32'h0, 8'hA5, 1'b0, 1'b0);
  endtask

  // Direct check of the outputs produced by the step just issued.
  task automatic expect_now(input string name, input logic [1:0] st, input logic [7:0] je);
    @(posedge clk);
    #1;
    check({name, "_state"}, 32'(state), 32'(st));
    check({name, "_joint"}, 32'(joint_enable), 32'(je));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_state"}, 32'(state), 32'h0);
    check({name, "_joint"}, 32'(joint_enable), 32'h0);
    check({name, "_accept"}, 32'(frame_accept), 32'h0);
    check({name, "_error"}, 32'(error), 32'h0);
    check({name, "_htx"}, header_tx, HDR_DATA);
    check({name, "_total"}, 32'(bad_total), 32'h0);
  endtask

  task automatic recover(input logic [7:0] en);
`ifdef FRAME_SUPERVISOR_FAULT_LATCH_EN
    good(en);
    expect_now("fault_hold", 2'b10, 8'h00);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    expect_now("fault_clear", 2'b00, 8'h00);
    good(en);
    expect_now("rearm_a", 2'b00, 8'h00);
`else
    good(en);
    expect_now("fault_exit", 2'b00, 8'h00);
`endif
    good(en);
    expect_now("rearm", 2'b01, en);
  endtask

  initial begin
    rst_n = 1'b1; frame_valid = 1'b0; header_rx = '0; cmd_enable = '0;
    estop_in = 1'b0; fault_clear = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Arming from IDLE
    idle(2);
    good(8'h1F);
    expect_now("arm1", 2'b00, 8'h00);
    idle(1);
    good(8'h1F);
    expect_now("arm2", 2'b01, 8'h1F);

    // Timeout boundary: good frame on the last cycle keeps RUN, silence one cycle longer faults
    idle(99);
    good(8'h0A);
    expect_now("tmo_edge_good", 2'b01, 8'h0A);
    idle(98);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    expect_now("tmo_99", 2'b01, 8'h0A);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    expect_now("tmo_100", 2'b10, 8'h00);
    check("tmo_error", 32'(error), 32'h1);
    recover(8'h1F);

    // Consecutive bad frames
    bad();
    bad();
    bad();
    expect_now("bad_limit", 2'b10, 8'h00);
    check("bad_total3", 32'(bad_total), 32'd3);
    recover(8'h1F);
    bad();
    good(8'h33);
    bad();
    bad();
    expect_now("bad_interleaved", 2'b01, 8'h33);

    // Emergency stop wins over a concurrent good frame
    step(1'b1, RX_HEADER, 8'hFF, 1'b1, 1'b0);
    expect_now("estop", 2'b11, 8'h00);
    check("estop_htx", header_tx, HDR_ESTOP);
    check("estop_error", 32'(error), 32'h1);
    idle(1);
    expect_now("estop_release", 2'b00, 8'h00);
    good(8'h55);
    good(8'h55);
    expect_now("estop_rearm", 2'b01, 8'h55);

    // Asynchronous reset mid-RUN
    good(8'h1F);
    expect_now("pre_reset", 2'b01, 8'h1F);
    #1 rst_n = 1'b0;
    sb.delete();
    frame_valid = 1'b0; estop_in = 1'b0; fault_clear = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with varying frame density
    for (int seg = 0; seg < 16; seg++) begin
      int rate;
      case ($urandom_range(0, 3))
        0:       rate = 0;
        1:       rate = 2;
        2:       rate = 25;
        default: rate = 60;
      endcase
      for (int i = 0; i < 250; i++) begin
        logic        fv, es, clr;
        logic [31:0] hdr;
        fv  = ($urandom_range(0, 99) < rate);
        hdr = ($urandom_range(0, 3) != 0) ? RX_HEADER : $urandom;
        es  = ($urandom_range(0, 199) == 0);
        clr = ($urandom_range(0, 49) == 0);
        step(fv, hdr, 8'($urandom), es, clr);
      end
    end

    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1 check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_supervisor.md
FRAME_SUPERVISOR -- requirements
Module: frame_supervisor

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 48000000, system clock in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 10000, maximum gap between good frames in RUN; TIMEOUT_CYCLES = (CLK_FREQ/1000000)*TIMEOUT_US.
REQ-003 SHALL have parameter RX_HEADER, default 32'h74697277, expected header of a good frame.
REQ-004 SHALL have parameter BAD_LIMIT, default 3, consecutive bad frames that force FAULT.
REQ-005 SHALL have parameter ARM_FRAMES, default 2, consecutive good frames required to leave IDLE.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port frame_valid, input, 1, one-cycle pulse marking a completed SPI frame.
REQ-009 SHALL have port header_rx, input, 32, header of that frame, sampled only when frame_valid=1.
REQ-010 SHALL have port cmd_enable, input, 8, per-joint enable bits of that frame, sampled only when frame_valid=1.
REQ-011 SHALL have port estop_in, input, 1, external emergency stop, synchronous to clk.
REQ-012 SHALL have port fault_clear, input, 1, one-cycle operator acknowledge.
REQ-013 SHALL have port joint_enable, output, 8, gated enables for the joint generators.
REQ-014 SHALL have port frame_accept, output, 1, one-cycle pulse per good frame.
REQ-015 SHALL have port state, output, 2, 00 IDLE, 01 RUN, 10 FAULT, 11 ESTOP.
REQ-016 SHALL have port error, output, 1, high in FAULT or ESTOP.
REQ-017 SHALL have port header_tx, output, 32, 32'h65737470 in ESTOP, else 32'h64617461.
REQ-018 SHALL have port bad_total, output, 16, saturating count of bad frames since reset.

Function
REQ-019 Good frame SHALL be frame_valid=1 with header_rx==RX_HEADER; bad frame SHALL be frame_valid=1 with any other header.
REQ-020 frame_accept, joint_enable, state, error and header_tx SHALL be registered, with 1-cycle latency from the causing input.
REQ-021 IDLE: joint_enable=0; arm counter increments per good frame and clears on a bad frame; on reaching ARM_FRAMES, SHALL go to RUN.
REQ-022 RUN: joint_enable SHALL load cmd_enable on each good frame and hold between frames.
REQ-023 RUN: a good frame SHALL reload the timeout counter to 0 and clear the consecutive-bad counter.
REQ-024 RUN: counter reaching TIMEOUT_CYCLES-1 with no good frame that cycle SHALL go to FAULT; a good frame in the same cycle wins.
REQ-025 RUN: a bad frame making consecutive-bad equal BAD_LIMIT SHALL go to FAULT.
REQ-026 FAULT: joint_enable=0 in the same cycle state becomes FAULT; exit per REQ-032/033.
REQ-027 estop_in=1 SHALL force ESTOP from any state, with priority over all other transitions; joint_enable=0.
REQ-028 ESTOP: estop_in=0 SHALL go to IDLE with arm counter cleared.
REQ-029 The timeout counter SHALL count only in RUN and SHALL reset to 0 on every entry to RUN.
REQ-030 bad_total SHALL increment on every bad frame in any state and saturate at 16'hFFFF.

Reset
REQ-031 rst_n=0 SHALL immediately set state=IDLE, joint_enable=0, frame_accept=0, error=0, header_tx=32'h64617461, bad_total=0, and clear all internal counters.

Configuration
REQ-032 Without FRAME_SUPERVISOR_FAULT_LATCH_EN, a good frame in FAULT SHALL go to IDLE with arm counter=1.
REQ-033 With FRAME_SUPERVISOR_FAULT_LATCH_EN defined, FAULT SHALL ignore frames and go to IDLE (arm counter=0) only on fault_clear=1.

Verification (CLK_FREQ=1000000, TIMEOUT_US=100, BAD_LIMIT=3, ARM_FRAMES=2)
REQ-034 Reset release; two good frames with cmd_enable=8'h1F -> state 00 then 01; joint_enable=8'h00 after the first frame and 8'h1F one cycle after the second.
REQ-035 RUN; no frames for 100 cycles -> state=10, error=1, joint_enable=8'h00; a good frame at cycle 99 instead -> stays 01.
REQ-036 RUN; three bad frames (header 32'h0) -> FAULT after the third; bad_total=3; bad,good,bad,bad -> stays RUN.
REQ-037 estop_in=1 during RUN concurrent with a good frame -> state=11, header_tx=32'h65737470, joint_enable=0; estop_in=0 -> IDLE; two good frames -> RUN.
REQ-038 FAULT; good frame -> IDLE (no macro); with macro, good frames ignored until fault_clear pulse -> IDLE.
REQ-039 rst_n low mid-RUN with joint_enable=8'h1F -> all outputs at reset values without a clk edge.
